goal_controller: RTL and testbench

Per-frame match sequencer for the soccer game. Each frame it compares the ball against both goal-post boxes and debounces entry. On a goal it credits the scoring side, freezes play for a celebration interval and pulses a round reset to the ball and player logic. It declares game over when a side reaches the winning score. It sits between the ball/player movers, the two goal-post instances (left and right) and the score/color mappers.

---
 rtl/goal_pkg.sv | 28 ++
 rtl/goal_zone_detect.sv | 28 ++
 rtl/goal_controller.sv | 207 ++++++++++++++++++++
 tb/tb_goal_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/goal_pkg.sv
// Shared types and widths for the goal sequencer and its zone detectors.
package goal_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CMP_W   = 11;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned DEB_W   = 3;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        GOAL      = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_t;

    // Zero-extend a screen coordinate so sums and differences cannot wrap.
    function automatic logic [CMP_W-1:0] widen(input logic [COORD_W-1:0] v);
        return CMP_W'(v);
    endfunction

endpackage

// File: rtl/goal_zone_detect.sv
// Combinational in-goal test of the ball against one goal-post box.
module goal_zone_detect
    import goal_pkg::*;
(
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] ball_s,
    input  logic [COORD_W-1:0] box_x,
    input  logic [COORD_W-1:0] box_y,
    input  logic [COORD_W-1:0] box_sx,
    input  logic [COORD_W-1:0] box_sy,
    output logic               in_goal
);

    logic [CMP_W-1:0] top;
    logic [CMP_W-1:0] right_edge;

    // Crossbar height saturates at screen top; centre inside mouth and ball fully below the bar.
    always_comb begin
        top        = (widen(box_y) >= widen(box_sy)) ? (widen(box_y) - widen(box_sy)) : '0;
        right_edge = widen(box_x) + widen(box_sx);
        in_goal    = (widen(ball_x) >= widen(box_x))
                  && (widen(ball_x) <  right_edge)
                  && (widen(ball_y) <= widen(box_y))
                  && (widen(ball_y) >  (top + widen(ball_s)));
    end

endmodule

// File: rtl/goal_controller.sv
// Per-frame match sequencer: goal debounce, scoring, celebration freeze, round reset, game over.
// Optional build macro GOAL_FREEZE_EN: when defined, GOAL holds for FREEZE_FRAMES frames;
// otherwise GOAL lasts a single frame and no freeze counter is built.
module goal_controller
    import goal_pkg::*;
#(
    parameter int unsigned WIN_SCORE     = 5,
    parameter int unsigned FREEZE_FRAMES = 120,
    parameter int unsigned DEBOUNCE      = 2
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [COORD_W-1:0] BallX,
    input  logic [COORD_W-1:0] BallY,
    input  logic [COORD_W-1:0] BallS,
    input  logic [COORD_W-1:0] LGoalX,
    input  logic [COORD_W-1:0] LGoalY,
    input  logic [COORD_W-1:0] LGoalSX,
    input  logic [COORD_W-1:0] LGoalSY,
    input  logic [COORD_W-1:0] RGoalX,
    input  logic [COORD_W-1:0] RGoalY,
    input  logic [COORD_W-1:0] RGoalSX,
    input  logic [COORD_W-1:0] RGoalSY,
    output logic [SCORE_W-1:0] ScoreL,
    output logic [SCORE_W-1:0] ScoreR,
    output logic               Freeze,
    output logic               RoundReset,
    output logic               GameOver,
    output logic               Winner,
    output logic [1:0]         State
);

    // Reject out-of-range configurations at elaboration.
    if (WIN_SCORE < 1 || WIN_SCORE > 15 || DEBOUNCE < 1 || DEBOUNCE > 7 || FREEZE_FRAMES < 1)
    begin : g_bad_cfg
        $error("goal_controller: parameter out of range");
    end

    state_t             state_q, state_n;
    logic [DEB_W-1:0]   deb_q, deb_n;
    side_t              prev_q, prev_n;
    side_t              side_q, side_n;
    side_t              winner_q, winner_n;
    score_t             score_l_q, score_l_n;
    score_t             score_r_q, score_r_n;
    logic               freeze_q, freeze_d;
    logic               round_reset_q, round_reset_d;
    logic               game_over_q, game_over_d;
    logic               in_l, in_r;
    logic               one_hit;
    side_t              hit_box;
    side_t              scorer;
    logic               goal_done;

`ifdef GOAL_FREEZE_EN
    localparam int unsigned FRZ_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;
    logic [FRZ_W-1:0]   frz_q, frz_n;
`endif

    goal_zone_detect u_left (
        .ball_x  (BallX),
        .ball_y  (BallY),
        .ball_s  (BallS),
        .box_x   (LGoalX),
        .box_y   (LGoalY),
        .box_sx  (LGoalSX),
        .box_sy  (LGoalSY),
        .in_goal (in_l)
    );

    goal_zone_detect u_right (
        .ball_x  (BallX),
        .ball_y  (BallY),
        .ball_s  (BallS),
        .box_x   (RGoalX),
        .box_y   (RGoalY),
        .box_sx  (RGoalSX),
        .box_sy  (RGoalSY),
        .in_goal (in_r)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= PLAY;
            deb_q         <= '0;
            prev_q        <= SIDE_LEFT;
            side_q        <= SIDE_LEFT;
            winner_q      <= SIDE_LEFT;
            score_l_q     <= '0;
            score_r_q     <= '0;
            freeze_q      <= 1'b0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
`ifdef GOAL_FREEZE_EN
            frz_q         <= '0;
`endif
        end else begin
            state_q       <= state_n;
            deb_q         <= deb_n;
            prev_q        <= prev_n;
            side_q        <= side_n;
            winner_q      <= winner_n;
            score_l_q     <= score_l_n;
            score_r_q     <= score_r_n;
            freeze_q      <= freeze_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
`ifdef GOAL_FREEZE_EN
            frz_q         <= frz_n;
`endif
        end
    end

    // Next state: debounce in PLAY, timed celebration in GOAL, win check, restart.
    always_comb begin
        state_n   = state_q;
        deb_n     = deb_q;
        prev_n    = prev_q;
        side_n    = side_q;
        winner_n  = winner_q;
        score_l_n = score_l_q;
        score_r_n = score_r_q;
        one_hit   = in_l ^ in_r;
        hit_box   = in_r ? SIDE_RIGHT : SIDE_LEFT;
        scorer    = in_r ? SIDE_LEFT : SIDE_RIGHT;
        goal_done = 1'b0;
`ifdef GOAL_FREEZE_EN
        frz_n     = frz_q;
`endif
        unique case (state_q)
            PLAY: begin
                if (one_hit) begin
                    deb_n  = (deb_q != '0 && prev_q == hit_box) ? (deb_q + DEB_W'(1)) : DEB_W'(1);
                    prev_n = hit_box;
                end else begin
                    deb_n  = '0;
                end
                if (one_hit && deb_n == DEB_W'(DEBOUNCE)) begin
                    deb_n   = '0;
                    side_n  = scorer;
                    state_n = GOAL;
                    if (scorer == SIDE_LEFT) begin
                        score_l_n = (score_l_q == '1) ? score_l_q : score_l_q + SCORE_W'(1);
                    end else begin
                        score_r_n = (score_r_q == '1) ? score_r_q : score_r_q + SCORE_W'(1);
                    end
`ifdef GOAL_FREEZE_EN
                    frz_n = FRZ_W'(FREEZE_FRAMES - 1);
`endif
                end
            end
            GOAL: begin
`ifdef GOAL_FREEZE_EN
                if (frz_q == '0) begin
                    goal_done = 1'b1;
                end else begin
                    frz_n = frz_q - FRZ_W'(1);
                end
`else
                goal_done = 1'b1;
`endif
                if (goal_done) begin
                    if (((side_q == SIDE_LEFT) ? score_l_q : score_r_q) == SCORE_W'(WIN_SCORE)) begin
                        state_n  = GAME_OVER;
                        winner_n = side_q;
                    end else begin
                        state_n  = RESPAWN;
                    end
                end
            end
            RESPAWN: begin
                deb_n   = '0;
                state_n = PLAY;
            end
            GAME_OVER: begin
                if (Start) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    winner_n  = SIDE_LEFT;
                    state_n   = RESPAWN;
                end
            end
            default: state_n = PLAY;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight off a flop.
    always_comb begin
        freeze_d      = 1'b0;
        round_reset_d = 1'b0;
        game_over_d   = 1'b0;
        freeze_d      = (state_n != PLAY);
        round_reset_d = (state_n == RESPAWN);
        game_over_d   = (state_n == GAME_OVER);
    end

    assign ScoreL     = score_l_q;
    assign ScoreR     = score_r_q;
    assign Freeze     = freeze_q;
    assign RoundReset = round_reset_q;
    assign GameOver   = game_over_q;
    assign Winner     = winner_q;
    assign State      = state_q;

endmodule

// File: tb/tb_goal_controller.sv
// Bench for goal_controller: directed match scenarios plus randomized ball traffic
// checked frame by frame against a history-based reference model.
module tb_goal_controller;

    localparam int unsigned WIN   = 5;
    localparam int unsigned FRZ   = 4;
    localparam int unsigned DEB   = 2;
`ifdef GOAL_FREEZE_EN
    localparam int GOAL_LEN = FRZ;
`else
    localparam int GOAL_LEN = 1;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [9:0] BallX, BallY, BallS;
    logic [9:0] LGoalX, LGoalY, LGoalSX, LGoalSY;
    logic [9:0] RGoalX, RGoalY, RGoalSX, RGoalSY;
    logic [3:0] ScoreL, ScoreR;
    logic       Freeze, RoundReset, GameOver, Winner;
    logic [1:0] State;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: scores, remaining celebration frames, flags and a window of recent hits.
    int m_sl, m_sr, m_goal_left, m_side, m_winner;
    bit m_resp, m_over;
    int hist[$];

    goal_controller #(.WIN_SCORE(WIN), .FREEZE_FRAMES(FRZ), .DEBOUNCE(DEB)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .Start     (Start),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .LGoalX    (LGoalX),
        .LGoalY    (LGoalY),
        .LGoalSX   (LGoalSX),
        .LGoalSY   (LGoalSY),
        .RGoalX    (RGoalX),
        .RGoalY    (RGoalY),
        .RGoalSX   (RGoalSX),
        .RGoalSY   (RGoalSY),
        .ScoreL    (ScoreL),
        .ScoreR    (ScoreR),
        .Freeze    (Freeze),
        .RoundReset(RoundReset),
        .GameOver  (GameOver),
        .Winner    (Winner),
        .State     (State)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic bit in_box(input int x, input int y, input int sx, input int sy,
                                  input int cx, input int cy, input int r);
        int top;
        top = (y > sy) ? (y - sy) : 0;
        return (cx >= x) && (cx < x + sx) && (cy <= y) && (cy > top + r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_state();
        if (m_over)          return 3;
        if (m_resp)          return 2;
        if (m_goal_left > 0) return 1;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ScoreL"},     32'(ScoreL),     32'(m_sl));
        chk({tag, ".ScoreR"},     32'(ScoreR),     32'(m_sr));
        chk({tag, ".State"},      32'(State),      32'(exp_state()));
        chk({tag, ".Freeze"},     32'(Freeze),     32'(exp_state() != 0));
        chk({tag, ".RoundReset"}, 32'(RoundReset), 32'(m_resp));
        chk({tag, ".GameOver"},   32'(GameOver),   32'(m_over));
        if (m_over) chk({tag, ".Winner"}, 32'(Winner), 32'(m_winner));
    endtask

    task automatic model_reset();
        m_sl = 0; m_sr = 0; m_goal_left = 0; m_side = 0; m_winner = 0;
        m_resp = 0; m_over = 0;
        hist.delete();
    endtask

    // One frame of the match rules; code is 0 none, 1 left box alone, 2 right box alone.
    task automatic model_step(input int code, input bit st);
        bit all_same;
        if (m_over) begin
            if (st) begin
                m_sl = 0; m_sr = 0; m_winner = 0; m_over = 0; m_resp = 1;
            end
        end else if (m_goal_left > 0) begin
            m_goal_left--;
            if (m_goal_left == 0) begin
                if ((m_side == 0 ? m_sl : m_sr) == int'(WIN)) begin
                    m_over = 1; m_winner = m_side;
                end else begin
                    m_resp = 1;
                end
            end
        end else if (m_resp) begin
            m_resp = 0;
            hist.delete();
        end else begin
            hist.push_back(code);
            if (hist.size() > int'(DEB)) void'(hist.pop_front());
            all_same = (hist.size() == int'(DEB)) && (code != 0);
            foreach (hist[i]) if (hist[i] != code) all_same = 0;
            if (all_same) begin
                m_side = (code == 2) ? 0 : 1;
                if (m_side == 0) m_sl = (m_sl < 15) ? m_sl + 1 : 15;
                else             m_sr = (m_sr < 15) ? m_sr + 1 : 15;
                m_goal_left = GOAL_LEN;
                hist.delete();
            end
        end
    endtask

    // Drive one frame at the falling edge, clock it, update the model and compare.
    task automatic frame(input string tag, input int cx, input int cy, input int r, input bit st);
        bit hl, hr;
        int code;
        BallX = 10'(cx); BallY = 10'(cy); BallS = 10'(r); Start = st;
        hl = in_box(int'(LGoalX), int'(LGoalY), int'(LGoalSX), int'(LGoalSY), cx, cy, r);
        hr = in_box(int'(RGoalX), int'(RGoalY), int'(RGoalSX), int'(RGoalSY), cx, cy, r);
        code = (hl && !hr) ? 1 : ((hr && !hl) ? 2 : 0);
        @(posedge frame_clk);
        #1;
        model_step(code, st);
        check_all(tag);
        @(negedge frame_clk);
    endtask

    task automatic idle_until_play(input string tag);
        int guard;
        guard = 0;
        while ((exp_state() != 0) && guard < 200) begin
            frame(tag, 300, 100, 8, 1'b0);
            guard++;
        end
        chk({tag, ".settle"}, 32'(exp_state()), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0;
        BallX = 10'd300; BallY = 10'd100; BallS = 10'd8;
        LGoalX = 10'd0;   LGoalY = 10'd460; LGoalSX = 10'd72; LGoalSY = 10'd128;
        RGoalX = 10'd567; RGoalY = 10'd460; RGoalSX = 10'd72; RGoalSY = 10'd128;
        model_reset();
        #12;
        check_all("reset");
        @(negedge frame_clk);
        Reset = 1'b0;

        // Left-goal hold: ScoreR on the second edge, then celebration and respawn.
        frame("lgoal1", 36, 440, 8, 1'b0);
        frame("lgoal2", 36, 440, 8, 1'b0);
        chk("lgoal.ScoreR", 32'(ScoreR), 32'd1);
        chk("lgoal.State",  32'(State),  32'd1);
        for (int i = 0; i < GOAL_LEN; i++) frame("lgoal_hold", 36, 440, 8, 1'b0);
        chk("lgoal.RoundReset", 32'(RoundReset), 32'd1);
        frame("lgoal_play", 36, 440, 8, 1'b0);
        chk("lgoal.back_play", 32'(State), 32'd0);
        idle_until_play("lgoal_idle");

        // Single-frame touches never score.
        for (int i = 0; i < 6; i++) begin
            frame("flick_in",  36, 440, 8, 1'b0);
            frame("flick_out", 300, 100, 8, 1'b0);
        end
        chk("flick.ScoreR", 32'(ScoreR), 32'd1);

        // Crossbar contact is not a goal; one pixel lower is.
        frame("bar1", 600, 340, 8, 1'b0);
        frame("bar2", 600, 340, 8, 1'b0);
        chk("bar.ScoreL", 32'(ScoreL), 32'd0);
        frame("below1", 600, 341, 8, 1'b0);
        frame("below2", 600, 341, 8, 1'b0);
        chk("below.ScoreL", 32'(ScoreL), 32'd1);
        idle_until_play("below_idle");

        // Both boxes reporting together counts as no hit.
        RGoalX = LGoalX; RGoalY = LGoalY; RGoalSX = LGoalSX; RGoalSY = LGoalSY;
        for (int i = 0; i < 4; i++) frame("both", 36, 440, 8, 1'b0);
        RGoalX = 10'd567; RGoalY = 10'd460; RGoalSX = 10'd72; RGoalSY = 10'd128;

        // Right goals until the left player wins; Start restarts the match.
        for (int g = 0; g < 10 && !m_over; g++) begin
            frame("rg1", 600, 400, 8, 1'b0);
            frame("rg2", 600, 400, 8, 1'b0);
            for (int i = 0; i < 200 && exp_state() != 0 && !m_over; i++)
                frame("rg_idle", 300, 100, 8, 1'b1);
        end
        chk("win.GameOver", 32'(GameOver), 32'd1);
        chk("win.Winner",   32'(Winner),   32'd0);
        chk("win.ScoreL",   32'(ScoreL),   32'd5);
        frame("over_hold", 600, 400, 8, 1'b0);
        frame("restart", 300, 100, 8, 1'b1);
        chk("restart.RoundReset", 32'(RoundReset), 32'd1);
        chk("restart.ScoreL",     32'(ScoreL),     32'd0);
        frame("restart_play", 300, 100, 8, 1'b0);

        // Reset in the middle of GOAL with ScoreR at 3.
        for (int g = 0; g < 3; g++) begin
            frame("r_g1", 36, 440, 8, 1'b0);
            frame("r_g2", 36, 440, 8, 1'b0);
            if (g < 2) idle_until_play("r_idle");
        end
        chk("rst.pre_ScoreR", 32'(ScoreR), 32'd3);
        chk("rst.pre_State",  32'(State),  32'd1);
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge frame_clk);
        #1;
        check_all("rst_held");
        @(negedge frame_clk);
        Reset = 1'b0;
        for (int i = 0; i < GOAL_LEN + 2; i++) frame("rst_after", 300, 100, 8, 1'b0);

        // Randomized traffic around both mouths, with occasional Start.
        for (int i = 0; i < 300; i++) begin
            int k, cx, cy, r, hold;
            bit st;
            k = int'($urandom_range(0, 9));
            if (k < 4) begin
                cx = int'($urandom_range(0, 80));
                cy = int'($urandom_range(320, 470));
            end else if (k < 8) begin
                cx = int'($urandom_range(560, 645));
                cy = int'($urandom_range(320, 470));
            end else begin
                cx = int'($urandom_range(0, 639));
                cy = int'($urandom_range(0, 479));
            end
            r    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 3));
            st   = ($urandom_range(0, 7) == 0);
            for (int h = 0; h < hold; h++) frame("rand", cx, cy, r, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
